rr_mux_arb: RTL and testbench

//   Parametrised, registered N-input multiplexer with a valid/ready handshake on

---
 rtl/rr_mux_arb.sv | 105 ++++++++++
 tb/tb_rr_mux_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// Registered N-input multiplexer with valid/ready handshakes on every port.
// Picks a fixed channel (SEL) or rotates round-robin over the requesting channels.
module rr_mux_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               MODE,
    input  logic [SELW-1:0]    SEL,
    input  logic [N*WIDTH-1:0] IN_DATA,
    input  logic [N-1:0]       IN_VALID,
    output logic [N-1:0]       IN_READY,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic [SELW-1:0]    OUT_CH,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    logic [WIDTH-1:0] chan_data [N];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic             can_load;
    logic             load;
    int               idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = IN_DATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search runs from the highest offset down so the nearest
    // requester to rr_ptr is the last one written and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (!MODE) begin
            if (int'(SEL) < N && IN_VALID[SEL]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (IN_VALID[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(idx);
                end
            end
        end
    end

    assign can_load = !out_valid_q || OUT_READY;
    assign load     = can_load && grant_valid;

    always_comb begin
        IN_READY = '0;
        if (RST_N && load) IN_READY[grant_idx] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[grant_idx];
            out_ch_d    = grant_idx;
            if (MODE) begin
                rr_ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed and randomized checks of rr_mux_arb against a transaction-level
// model that tracks the output register and round-robin pointer.
module tb_rr_mux_arb;

    localparam int N = 4;
    localparam int WIDTH = 8;
    localparam int SELW = 2;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               MODE;
    logic [SELW-1:0]    SEL;
    logic [N*WIDTH-1:0] IN_DATA;
    logic [N-1:0]       IN_VALID;
    logic [N-1:0]       IN_READY;
    logic [WIDTH-1:0]   OUT_DATA;
    logic [SELW-1:0]    OUT_CH;
    logic               OUT_VALID;
    logic               OUT_READY;

    logic [WIDTH-1:0] din [N];
    assign IN_DATA = {din[3], din[2], din[1], din[0]};

    rr_mux_arb #(.N(N), .WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .SEL(SEL),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference state: what the consumer should see, plus the rotation start.
    bit       m_valid;
    int       m_data;
    int       m_ch;
    int       m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (!MODE) return IN_VALID[SEL] ? int'(SEL) : -1;
        for (int k = 0; k < N; k++) begin
            if (IN_VALID[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: check handshake before the edge, update the model, check outputs after.
    task automatic step();
        int g;
        bit can_load;
        logic [N-1:0] exp_ready;
        #1;
        can_load  = !m_valid || OUT_READY;
        g         = model_grant();
        exp_ready = '0;
        if (RST_N && can_load && g >= 0) exp_ready[g] = 1'b1;
        check("in_ready", 32'(IN_READY), 32'(exp_ready));
        @(posedge CLK);
        if (!RST_N) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (can_load && g >= 0) begin
            m_valid = 1; m_data = int'(din[g]); m_ch = g;
            if (MODE) m_ptr = (g + 1) % N;
        end else if (OUT_READY) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 32'(OUT_VALID), 32'(m_valid));
        check("out_data", 32'(OUT_DATA), 32'(m_data));
        check("out_ch", 32'(OUT_CH), 32'(m_ch));
        $display("t=%0t rst_n=%0b mode=%0b sel=%0d vld=%b rdy=%b ord=%0b -> ov=%0b od=%02h oc=%0d",
                 $time, RST_N, MODE, SEL, IN_VALID, IN_READY, OUT_READY, OUT_VALID, OUT_DATA, OUT_CH);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
    endtask

    initial begin
        int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        MODE = 1'b1; SEL = '0; OUT_READY = 1'b1; IN_VALID = 4'b1111;
        din[0] = 8'h10; din[1] = 8'h20; din[2] = 8'h30; din[3] = 8'h40;
        RST_N = 1'b0;
        @(posedge CLK);

        // 1: reset with every channel valid, then first grant is ch0
        step();
        step();
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_data", 32'(OUT_DATA), 32'h00);
        check("rst_in_ready", 32'(IN_READY), 32'b0000);
        RST_N = 1'b1;
        #1;
        check("first_grant_ch0", 32'(IN_READY), 32'b0001);
        step();

        // 2: fixed select of ch2; rotation pointer must not move
        do_reset();
        MODE = 1'b0; SEL = 2'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            check("fixed_data", 32'(OUT_DATA), 32'h30);
            check("fixed_ch", 32'(OUT_CH), 32'd2);
        end
        MODE = 1'b1;
        #1;
        check("fixed_ptr_held", 32'(IN_READY), 32'b0001);

        // 3: round-robin over 1011, one transfer per cycle
        do_reset();
        IN_VALID = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_seq_ch", 32'(OUT_CH), 32'(exp_seq[i]));
            check("rr_seq_valid", 32'(OUT_VALID), 32'd1);
        end

        // 4: back-pressure holds ch1 data, then resumes in the same cycle
        do_reset();
        IN_VALID = 4'b1111; MODE = 1'b0; SEL = 2'd1;
        step();
        OUT_READY = 1'b0; MODE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_data", 32'(OUT_DATA), 32'h20);
            check("hold_ch", 32'(OUT_CH), 32'd1);
            check("hold_in_ready", 32'(IN_READY), 32'b0000);
        end
        OUT_READY = 1'b1;
        #1;
        check("resume_grant", 32'(IN_READY), 32'b0001);
        step();

        // 5: wrap from ch3, then ch0, then drain to idle
        do_reset();
        IN_VALID = 4'b1000;
        step();
        check("wrap_ch3", 32'(OUT_CH), 32'd3);
        IN_VALID = 4'b0001;
        step();
        check("after_wrap_ch0", 32'(OUT_CH), 32'd0);
        IN_VALID = 4'b0000;
        step();
        check("drain_idle", 32'(OUT_VALID), 32'd0);

        // 6: reset while output is held drops the data
        IN_VALID = 4'b0100;
        step();
        OUT_READY = 1'b0;
        step();
        IN_VALID = 4'b1111;
        do_reset();
        check("midrst_valid", 32'(OUT_VALID), 32'd0);
        OUT_READY = 1'b1;
        #1;
        check("midrst_ptr0", 32'(IN_READY), 32'b0001);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) din[c] = 8'($urandom);
            IN_VALID  = 4'($urandom);
            MODE      = ($urandom_range(0, 3) != 0);
            SEL       = 2'($urandom);
            OUT_READY = ($urandom_range(0, 2) != 0);
            RST_N     = ($urandom_range(0, 40) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
